// File: rtl/updown_mod_counter_if.sv
// updown_mod_counter_if: control and status bundle for updown_mod_counter; COUNTER_STICKY_STATUS_EN adds STATUS_CLR/STATUS.
interface updown_mod_counter_if #(
  parameter int WIDTH = 8
);
  logic             EN;
  logic             UP;
  logic             LOAD;
  logic [WIDTH-1:0] LOAD_VAL;
  logic             CLR;
  logic [WIDTH-1:0] Q;
  logic             TC;
  logic             OVF;
  logic             UNF;
`ifdef COUNTER_STICKY_STATUS_EN
  logic             STATUS_CLR;
  logic [1:0]       STATUS;
  modport master (output EN, UP, LOAD, LOAD_VAL, CLR, STATUS_CLR, input Q, TC, OVF, UNF, STATUS);
  modport slave  (input EN, UP, LOAD, LOAD_VAL, CLR, STATUS_CLR, output Q, TC, OVF, UNF, STATUS);
`else
  modport master (output EN, UP, LOAD, LOAD_VAL, CLR, input Q, TC, OVF, UNF);
  modport slave  (input EN, UP, LOAD, LOAD_VAL, CLR, output Q, TC, OVF, UNF);
`endif
endinterface

// File: rtl/updown_mod_counter.sv
// updown_mod_counter: modulo up/down counter with load, clear, wrap/saturate and enable prescaler.
// Define COUNTER_STICKY_STATUS_EN to add sticky overflow/underflow STATUS with STATUS_CLR.
module updown_mod_counter #(
  parameter int WIDTH    = 8,
  parameter int MODULUS  = 256,
  parameter bit SATURATE = 1'b0,
  parameter int PRESCALE = 1
) (
  input  logic CLK,
  input  logic RESET,
  updown_mod_counter_if.slave bus
);
  localparam int               PW   = PRESCALE > 1 ? $clog2(PRESCALE) : 1;
  localparam logic [WIDTH-1:0] MAX  = WIDTH'(MODULUS - 1);
  localparam logic [PW-1:0]    PMAX = PW'(PRESCALE - 1);
  logic [WIDTH-1:0] q_q, q_d;
  logic [PW-1:0]    pre_q, pre_d;
  logic             ovf_q, ovf_d, unf_q, unf_d, step;
  always_comb begin
    q_d   = q_q;
    pre_d = pre_q;
    ovf_d = 1'b0;
    unf_d = 1'b0;
    step  = !bus.CLR && !bus.LOAD && bus.EN && pre_q == PMAX;
    if (bus.CLR) begin
      q_d   = '0;
      pre_d = '0;
    end else if (bus.LOAD) begin
      q_d   = bus.LOAD_VAL > MAX ? MAX : bus.LOAD_VAL;
      pre_d = '0;
    end else if (bus.EN) begin
      pre_d = step ? '0 : pre_q + 1'b1;
    end
    // at a limit the step either wraps or holds, and flags the attempt either way
    if (step && bus.UP) begin
      ovf_d = q_q == MAX;
      q_d   = q_q != MAX ? q_q + 1'b1 : SATURATE ? q_q : '0;
    end
    if (step && !bus.UP) begin
      unf_d = q_q == '0;
      q_d   = q_q != '0 ? q_q - 1'b1 : SATURATE ? q_q : MAX;
    end
  end
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      q_q   <= '0;
      pre_q <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      q_q   <= q_d;
      pre_q <= pre_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end
  assign bus.Q   = q_q;
  assign bus.OVF = ovf_q;
  assign bus.UNF = unf_q;
  assign bus.TC  = bus.UP ? q_q == MAX : q_q == '0;
`ifdef COUNTER_STICKY_STATUS_EN
  logic [1:0] status_q, status_d;
  always_comb status_d = (bus.STATUS_CLR ? 2'b00 : status_q) | {unf_d, ovf_d};
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) status_q <= 2'b00;
    else status_q <= status_d;
  end
  assign bus.STATUS = status_q;
`endif
endmodule

// File: tb/tb_updown_mod_counter.sv
// tb_updown_mod_counter: four counter configurations driven in parallel and checked against an arithmetic model.
module tb_updown_mod_counter;
  localparam int N = 4;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en = 1'b0, up = 1'b1, load = 1'b0, clr = 1'b0;
  logic [3:0] load_val = '0;
  logic [3:0] q_o [N];
  logic tc_o [N], ovf_o [N], unf_o [N];
  int mq [N], mpre [N];
  bit movf [N], munf [N];
  int n_tests = 0, n_fail = 0;

  always #5 clk = ~clk;

  updown_mod_counter_if #(.WIDTH(4)) bi [N] ();

  // instance 0: wrap mod 10; 1: saturate mod 10; 2: prescale 3 mod 10; 3: wrap mod 16
  for (genvar g = 0; g < N; g++) begin : gd
    assign bi[g].EN       = en;
    assign bi[g].UP       = up;
    assign bi[g].LOAD     = load;
    assign bi[g].LOAD_VAL = load_val;
    assign bi[g].CLR      = clr;
`ifdef COUNTER_STICKY_STATUS_EN
    assign bi[g].STATUS_CLR = 1'b0;
`endif
    assign q_o[g]   = bi[g].Q;
    assign tc_o[g]  = bi[g].TC;
    assign ovf_o[g] = bi[g].OVF;
    assign unf_o[g] = bi[g].UNF;
    updown_mod_counter #(
      .WIDTH(4), .MODULUS(g == 3 ? 16 : 10), .SATURATE(g == 1), .PRESCALE(g == 2 ? 3 : 1)
    ) dut (.CLK(clk), .RESET(rst), .bus(bi[g]));
  end

  function automatic int mod_of(int i);
    return i == 3 ? 16 : 10;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      mq[i] = 0;
      mpre[i] = 0;
      movf[i] = 0;
      munf[i] = 0;
    end
  endtask

  task automatic model_edge();
    int m, p, nxt;
    if (rst) begin
      model_reset();
      return;
    end
    for (int i = 0; i < N; i++) begin
      m = mod_of(i);
      p = i == 2 ? 3 : 1;
      movf[i] = 0;
      munf[i] = 0;
      if (clr) begin
        mq[i] = 0;
        mpre[i] = 0;
      end else if (load) begin
        mq[i] = int'(load_val) >= m ? m - 1 : int'(load_val);
        mpre[i] = 0;
      end else if (en) begin
        mpre[i] = (mpre[i] + 1) % p;
        if (mpre[i] == 0) begin
          nxt = up ? (mq[i] + 1) % m : (mq[i] + m - 1) % m;
          movf[i] = up && nxt == 0;
          munf[i] = !up && nxt == m - 1;
          if (!(i == 1 && (movf[i] || munf[i]))) mq[i] = nxt;
        end
      end
    end
  endtask

  task automatic check_all();
    for (int i = 0; i < N; i++) begin
      chk($sformatf("q%0d", i), 32'(q_o[i]), 32'(mq[i]));
      chk($sformatf("tc%0d", i), 32'(tc_o[i]), 32'(up ? mq[i] == mod_of(i) - 1 : mq[i] == 0));
      chk($sformatf("ovf%0d", i), 32'(ovf_o[i]), 32'(movf[i]));
      chk($sformatf("unf%0d", i), 32'(unf_o[i]), 32'(munf[i]));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1 check_all();
  endtask

  initial begin
    model_reset();
    #1 check_all();
    repeat (2) tick();
    rst = 1'b0;
    up = 1'b1;
    en = 1'b1;
    repeat (12) tick();
    chk("up_wrap_q", 32'(q_o[0]), 32'd2);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    up = 1'b0;
    repeat (2) tick();
    chk("down_wrap_q", 32'(q_o[0]), 32'd8);
    en = 1'b0;
    load = 1'b1;
    load_val = 4'd15;
    tick();
    chk("load_clamp", 32'(q_o[0]), 32'd9);
    load_val = 4'd4;
    tick();
    clr = 1'b1;
    tick();
    chk("clr_over_load", 32'(q_o[0]), 32'd0);
    clr = 1'b0;
    en = 1'b1;
    load_val = 4'd7;
    tick();
    chk("load_over_step", 32'(q_o[0]), 32'd7);
    load_val = 4'd5;
    tick();
    load = 1'b0;
    en = 1'b0;
    #2 rst = 1'b1;
    #1 model_reset();
    check_all();
    chk("async_rst", 32'(q_o[0]), 32'd0);
    repeat (3) tick();
    rst = 1'b0;
    load = 1'b1;
    load_val = 4'd9;
    tick();
    load = 1'b0;
    up = 1'b1;
    en = 1'b1;
    repeat (3) tick();
    chk("sat_hold", 32'(q_o[1]), 32'd9);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    up = 1'b0;
    tick();
    chk("sat_unf", 32'(unf_o[1]), 32'd1);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    up = 1'b1;
    repeat (9) tick();
    chk("prescale_q", 32'(q_o[2]), 32'd3);
    en = 1'b0;
    repeat (2) tick();
    en = 1'b1;
    repeat (3) tick();
    chk("prescale_gap", 32'(q_o[2]), 32'd4);
    for (int k = 0; k < 3000; k++) begin
      en       = $urandom_range(0, 9) < 7;
      clr      = $urandom_range(0, 99) < 3;
      load     = $urandom_range(0, 99) < 5;
      load_val = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 9) == 0) up = ~up;
      tick();
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
